universal_shift_reg_n: RTL and testbench

Parametrised universal shift register, the successor to the fixed 4-bit universal shift register. It adds configurable width, multi-bit shift/rotate amounts executed one bit per clock, arithmetic shift, serial inputs at both ends and a shifted-out flag. Operations use a start/busy/done handshake, so a controller can issue back-to-back operations. It sits in datapaths as a general-purpose shifter and serialiser.

---
 rtl/usr_pkg.sv | 25 ++
 rtl/usr_step.sv | 55 +++++
 rtl/universal_shift_reg_n.sv | 114 +++++++++++
 tb/tb_universal_shift_reg_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode codes, FSM state type and mode classification for the
// parametrised universal shift register.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Shift/rotate modes take their step count from amt; the rest take one step.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step datapath: computes the next register value and
// the bit leaving the register for one clock of the selected operation.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic             ser_msb_i,
  input  logic             ser_lsb_i,
  output logic [WIDTH-1:0] next_o,
  output logic             out_bit_o,
  output logic             shifted_o
);

  always_comb begin
    next_o    = cur_i;
    out_bit_o = 1'b0;
    shifted_o = 1'b0;
    case (mode_i)
      MODE_HOLD: next_o = cur_i;
      MODE_SHR: begin
        next_o    = {ser_msb_i, cur_i[WIDTH-1:1]};
        out_bit_o = cur_i[0];
        shifted_o = 1'b1;
      end
      MODE_SHL: begin
        next_o    = {cur_i[WIDTH-2:0], ser_lsb_i};
        out_bit_o = cur_i[WIDTH-1];
        shifted_o = 1'b1;
      end
      MODE_LOAD: next_o = load_i;
      MODE_ROR: begin
        next_o    = {cur_i[0], cur_i[WIDTH-1:1]};
        out_bit_o = cur_i[0];
        shifted_o = 1'b1;
      end
      MODE_ROL: begin
        next_o    = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
        out_bit_o = cur_i[WIDTH-1];
        shifted_o = 1'b1;
      end
      MODE_ASR: begin
        next_o    = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
        out_bit_o = cur_i[0];
        shifted_o = 1'b1;
      end
      MODE_CLR: next_o = '0;
      default:  next_o = cur_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// Universal shift register with multi-bit shift/rotate executed one bit per
// clock behind a start/busy/done handshake.
//
// state   | meaning
// ST_IDLE | waiting for start; operands latched when start=1
// ST_RUN  | applying one step per edge until the step counter expires
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       S,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] I,
  input  logic             ser_msb_in,
  input  logic             ser_lsb_in,
  output logic [WIDTH-1:0] O,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   ldat_q, ldat_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   o_q, o_d;
  logic               sout_q, sout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_next;
  logic               step_out;
  logic               step_shifted;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .mode_i    (mode_q),
    .cur_i     (o_q),
    .load_i    (ldat_q),
    .ser_msb_i (ser_msb_in),
    .ser_lsb_i (ser_lsb_in),
    .next_o    (step_next),
    .out_bit_o (step_out),
    .shifted_o (step_shifted)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ldat_d  = ldat_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = S;
          ldat_d  = I;
          busy_d  = 1'b1;
          cnt_d   = is_shift_mode(S) ? amt : AMT_W'(1);
        end
      end
      ST_RUN: begin
        // A zero count still spends one RUN cycle so done always follows start.
        if (cnt_q != '0) begin
          o_d   = step_next;
          cnt_d = cnt_q - AMT_W'(1);
          if (step_shifted) sout_d = step_out;
        end
        if (cnt_q <= AMT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      ldat_q  <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ldat_q  <= ldat_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O    = o_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed, scoreboarded bench for universal_shift_reg_n (WIDTH=8, AMT_W=4).
module tb_universal_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             clear;
  logic             start;
  logic [2:0]       S;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] I;
  logic             ser_msb_in;
  logic             ser_lsb_in;
  logic [WIDTH-1:0] O;
  logic             sout;
  logic             busy;
  logic             done;

  universal_shift_reg_n #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .S          (S),
    .amt        (amt),
    .I          (I),
    .ser_msb_in (ser_msb_in),
    .ser_lsb_in (ser_lsb_in),
    .O          (O),
    .sout       (sout),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] o;
    logic             so;
    logic             bz;
    logic             dn;
  } exp_t;

  exp_t             exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] m_o;
  logic             m_so;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one step of the selected operation.
  task automatic model_step(input logic [2:0] s, input logic [WIDTH-1:0] i,
                            input logic msb, input logic lsb);
    case (s)
      3'b001: begin m_so = m_o[0];       m_o = m_o >> 1; m_o[WIDTH-1] = msb; end
      3'b010: begin m_so = m_o[WIDTH-1]; m_o = m_o << 1; m_o[0] = lsb; end
      3'b011: m_o = i;
      3'b100: begin m_so = m_o[0];       m_o = (m_o >> 1) | (m_o << (WIDTH-1)); end
      3'b101: begin m_so = m_o[WIDTH-1]; m_o = (m_o << 1) | (m_o >> (WIDTH-1)); end
      3'b110: begin m_so = m_o[0];       m_o = $unsigned($signed(m_o) >>> 1); end
      3'b111: m_o = '0;
      default: ;
    endcase
  endtask

  // Pushes the observation expected after each edge k..k+n of one operation.
  task automatic push_op(input string tag, input logic [2:0] s, input logic [AMT_W-1:0] a,
                         input logic [WIDTH-1:0] i, input logic msb, input logic lsb);
    int n;
    n = (s inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110}) ? int'(a) : 1;
    exp_q.push_back('{tag, m_o, m_so, 1'b1, 1'b0});
    if (n == 0) exp_q.push_back('{tag, m_o, m_so, 1'b0, 1'b1});
    for (int j = 1; j <= n; j++) begin
      model_step(s, i, msb, lsb);
      exp_q.push_back('{tag, m_o, m_so, (j < n), (j == n)});
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_O"},    32'(O),    32'(e.o));
    check({e.tag, "_sout"}, 32'(sout), 32'(e.so));
    check({e.tag, "_busy"}, 32'(busy), 32'(e.bz));
    check({e.tag, "_done"}, 32'(done), 32'(e.dn));
  endtask

  task automatic drain(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      pop_cmp();
    end
  endtask

  // Drives one operation; start drops after edge k and the scoreboard drains.
  task automatic run_op(input string tag, input logic [2:0] s, input logic [AMT_W-1:0] a,
                        input logic [WIDTH-1:0] i, input logic msb, input logic lsb);
    S = s; amt = a; I = i; ser_msb_in = msb; ser_lsb_in = lsb;
    push_op(tag, s, a, i, msb, lsb);
    start = 1'b1;
    tick();
    pop_cmp();
    start = 1'b0;
    drain(exp_q.size());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; start = 1'b0; S = 3'b000; amt = '0; I = '0;
    ser_msb_in = 1'b0; ser_lsb_in = 1'b0;
    m_o = '0; m_so = 1'b0;

    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_O", 32'(O), 32'h0);
      check("rst_busy_done_sout", {29'd0, busy, done, sout}, 32'h0);
    end
    clear = 1'b1;
    tick();

    run_op("t1_load", 3'b011, 4'd0, 8'hA5, 1'b0, 1'b0);
    check("t1_final_O", 32'(O), 32'hA5);

    run_op("t2_ror3", 3'b100, 4'd3, 8'h00, 1'b0, 1'b0);
    check("t2_final_O", 32'(O), 32'hB4);
    check("t2_final_sout", 32'(sout), 32'h1);

    run_op("t3_load90", 3'b011, 4'd0, 8'h90, 1'b0, 1'b0);
    run_op("t3_asr2", 3'b110, 4'd2, 8'h00, 1'b0, 1'b0);
    check("t3_final_O", 32'(O), 32'hE4);
    check("t3_final_sout", 32'(sout), 32'h0);

    run_op("t4_load0f", 3'b011, 4'd0, 8'h0F, 1'b0, 1'b0);
    S = 3'b010; amt = 4'd4; ser_lsb_in = 1'b1;
    push_op("t4_shl4", 3'b010, 4'd4, 8'h00, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    pop_cmp();
    S = 3'b111; amt = 4'd9; I = 8'h12;
    drain(4);
    start = 1'b0;
    exp_q.push_back('{"t4_no_extra", m_o, m_so, 1'b0, 1'b0});
    drain(2 - 1);
    check("t4_final_O", 32'(O), 32'hFF);

    S = 3'b001; amt = 4'd0;
    push_op("t5_amt0", 3'b001, 4'd0, 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    pop_cmp();
    start = 1'b0;
    drain(1);
    S = 3'b011; I = 8'h3C;
    push_op("t5_b2b_load", 3'b011, 4'd0, 8'h3C, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    pop_cmp();
    start = 1'b0;
    drain(exp_q.size());
    check("t5_final_O", 32'(O), 32'h3C);

    run_op("t6_load81", 3'b011, 4'd0, 8'h81, 1'b0, 1'b0);
    S = 3'b101; amt = 4'd6;
    push_op("t6_rol6", 3'b101, 4'd6, 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    pop_cmp();
    start = 1'b0;
    drain(2);
    check("t6_mid_O", 32'(O), 32'h06);
    exp_q.delete();
    clear = 1'b0;
    #1;
    check("t6_abort_O", 32'(O), 32'h0);
    check("t6_abort_busy", 32'(busy), 32'h0);
    m_o = '0; m_so = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("t6_no_done", 32'(done), 32'h0);
    end
    clear = 1'b1;
    tick();
    run_op("t6_load55", 3'b011, 4'd0, 8'h55, 1'b0, 1'b0);
    check("t6_final_O", 32'(O), 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
